mul_pipeline: RTL and testbench

Parametrised integer multiply pipeline for the core. It replaces the hard-wired five-latch exe→mult1…mult5 chain with a single block of configurable depth.
- Carries instruction, pc, write address and write enable alongside the product.
- Supports stall and flush.
- Answers decode-stage operand queries, raising a hazard when the result is not yet ready and a bypass when it is.
- Sits beside int_alu after dec_exe_latch; its output feeds the writeback latch and bypass_ctrl.

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_stage_reg.sv | 26 ++
 rtl/mul_pipeline.sv | 154 +++++++++++++++
 tb/tb_mul_pipeline.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the integer multiply pipeline.
// Funct encodings and the default stage bundle.
package mul_pkg;

  localparam logic [1:0] MUL_LO  = 2'd0;
  localparam logic [1:0] MUL_HSS = 2'd1;
  localparam logic [1:0] MUL_HSU = 2'd2;
  localparam logic [1:0] MUL_HUU = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] instr;
    logic [31:0] pc;
  } mul_stage_t;

endpackage

// File: rtl/mul_stage_reg.sv
// One multiply pipeline stage register.
// Flush drops only valid; stall holds the whole bundle.
module mul_stage_reg
  import mul_pkg::*;
#(
  parameter type stage_t = mul_stage_t
) (
  input  logic   clk_i,
  input  logic   rsn_i,
  input  logic   stall_i,
  input  logic   flush_i,
  input  stage_t d_i,
  output stage_t q_o
);

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      q_o <= '0;
    end else if (flush_i) begin
      q_o.valid <= 1'b0;
    end else if (!stall_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mul_pipeline.sv
// Integer multiply pipeline of DEPTH stages with hazard/bypass query.
// MUL_HIGH_EN enables MULH/MULHSU/MULHU; otherwise only the low product.
module mul_pipeline
  import mul_pkg::*;
#(
  parameter int DEPTH  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [1:0]        funct_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic              int_write_enable_i,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       pc_i,
  input  logic [ADDR_W-1:0] read_addr_a_i,
  input  logic [ADDR_W-1:0] read_addr_b_i,
  output logic              hazard_a_o,
  output logic              hazard_b_o,
  output logic              bypass_a_en_o,
  output logic              bypass_b_en_o,
  output logic [DATA_W-1:0] bypass_data_o,
  output logic              wb_valid_o,
  output logic [ADDR_W-1:0] wb_write_addr_o,
  output logic              wb_int_write_enable_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [31:0]       wb_instr_o,
  output logic [31:0]       wb_pc_o,
  output logic              busy_o
);

  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("mul_pipeline: DEPTH must be in 1..16");
  end

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] waddr;
    logic              we;
    logic [31:0]       instr;
    logic [31:0]       pc;
  } stage_t;

  logic [DATA_W-1:0] result;

`ifdef MUL_HIGH_EN
  logic                       sa;
  logic                       sb;
  logic signed [DATA_W:0]     a_x;
  logic signed [DATA_W:0]     b_x;
  logic signed [2*DATA_W-1:0] p_full;

  // One extra sign bit per operand covers all four signedness mixes
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (1'b1)
      (funct_i == MUL_HSS): begin
        sa = 1'b1;
        sb = 1'b1;
      end
      (funct_i == MUL_HSU): sa = 1'b1;
      default: ;
    endcase
    a_x    = {sa & data_a_i[DATA_W-1], data_a_i};
    b_x    = {sb & data_b_i[DATA_W-1], data_b_i};
    p_full = (2*DATA_W)'(a_x) * (2*DATA_W)'(b_x);
    result = (funct_i == MUL_LO) ? p_full[DATA_W-1:0]
                                 : p_full[2*DATA_W-1:DATA_W];
  end
`else
  logic funct_unused;

  assign funct_unused = ^funct_i;
  assign result       = data_a_i * data_b_i;
`endif

  stage_t d [DEPTH];
  stage_t q [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign d[k] = '{
        valid: valid_i,
        data:  result,
        waddr: write_addr_i,
        we:    int_write_enable_i,
        instr: instr_i,
        pc:    pc_i
      };
    end else begin : g_tail
      assign d[k] = q[k-1];
    end

    mul_stage_reg #(
      .stage_t (stage_t)
    ) u_stage (
      .clk_i   (clk_i),
      .rsn_i   (rsn_i),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .d_i     (d[k]),
      .q_o     (q[k])
    );
  end

  function automatic logic hit(
    input stage_t            s,
    input logic [ADDR_W-1:0] ra
  );
    return s.valid && s.we &&
           (s.waddr == ra) && (ra != '0);
  endfunction

  logic hz_a;
  logic hz_b;
  logic any_v;

  always_comb begin
    hz_a  = 1'b0;
    hz_b  = 1'b0;
    any_v = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      hz_a = hz_a | hit(q[k], read_addr_a_i);
      hz_b = hz_b | hit(q[k], read_addr_b_i);
    end
    for (int k = 0; k < DEPTH; k++) begin
      any_v = any_v | q[k].valid;
    end
  end

  // A younger pending producer shadows the one ready in the last stage
  assign hazard_a_o    = hz_a;
  assign hazard_b_o    = hz_b;
  assign bypass_a_en_o = hit(q[DEPTH-1], read_addr_a_i) && !hz_a;
  assign bypass_b_en_o = hit(q[DEPTH-1], read_addr_b_i) && !hz_b;
  assign bypass_data_o = q[DEPTH-1].data;

  assign wb_valid_o            = q[DEPTH-1].valid;
  assign wb_write_addr_o       = q[DEPTH-1].waddr;
  assign wb_int_write_enable_o = q[DEPTH-1].valid & q[DEPTH-1].we;
  assign wb_data_o             = q[DEPTH-1].data;
  assign wb_instr_o            = q[DEPTH-1].instr;
  assign wb_pc_o               = q[DEPTH-1].pc;
  assign busy_o                = any_v;

endmodule

// File: tb/tb_mul_pipeline.sv
// Scoreboard bench for mul_pipeline (DEPTH=5, 32-bit).
// Directed vectors; a negedge monitor checks every writeback.
module tb_mul_pipeline;
  import mul_pkg::*;

  localparam int DEPTH = 5;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        stall_i;
  logic        flush_i;
  logic        valid_i;
  logic [1:0]  funct_i;
  logic [31:0] data_a_i;
  logic [31:0] data_b_i;
  logic [4:0]  write_addr_i;
  logic        int_write_enable_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [4:0]  read_addr_a_i;
  logic [4:0]  read_addr_b_i;
  logic        hazard_a_o;
  logic        hazard_b_o;
  logic        bypass_a_en_o;
  logic        bypass_b_en_o;
  logic [31:0] bypass_data_o;
  logic        wb_valid_o;
  logic [4:0]  wb_write_addr_o;
  logic        wb_int_write_enable_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_instr_o;
  logic [31:0] wb_pc_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  mul_pipeline #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk_i                 (clk_i),
    .rsn_i                 (rsn_i),
    .stall_i               (stall_i),
    .flush_i               (flush_i),
    .valid_i               (valid_i),
    .funct_i               (funct_i),
    .data_a_i              (data_a_i),
    .data_b_i              (data_b_i),
    .write_addr_i          (write_addr_i),
    .int_write_enable_i    (int_write_enable_i),
    .instr_i               (instr_i),
    .pc_i                  (pc_i),
    .read_addr_a_i         (read_addr_a_i),
    .read_addr_b_i         (read_addr_b_i),
    .hazard_a_o            (hazard_a_o),
    .hazard_b_o            (hazard_b_o),
    .bypass_a_en_o         (bypass_a_en_o),
    .bypass_b_en_o         (bypass_b_en_o),
    .bypass_data_o         (bypass_data_o),
    .wb_valid_o            (wb_valid_o),
    .wb_write_addr_o       (wb_write_addr_o),
    .wb_int_write_enable_o (wb_int_write_enable_o),
    .wb_data_o             (wb_data_o),
    .wb_instr_o            (wb_instr_o),
    .wb_pc_o               (wb_pc_o),
    .busy_o                (busy_o)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  exp_t        last;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        adv = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    adv <= rsn_i && !stall_i && !flush_i;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (wb_valid_o && adv) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got rd %0d data %h expected none",
                 wb_write_addr_o, wb_data_o);
      end else begin
        e = sbq.pop_front();
        chk("wb_cycle", cyc, e.due);
        chk("wb_data", wb_data_o, e.data);
        chk("wb_addr", 32'(wb_write_addr_o), 32'(e.addr));
        chk("wb_we", 32'(wb_int_write_enable_o), 32'(e.we));
        chk("wb_instr", wb_instr_o, e.instr);
        chk("wb_pc", wb_pc_o, e.pc);
        last = e;
      end
    end else if (wb_valid_o) begin
      chk("hold_data", wb_data_o, last.data);
      chk("hold_addr", 32'(wb_write_addr_o), 32'(last.addr));
    end else begin
      chk("idle_we", 32'(wb_int_write_enable_o), 32'd0);
    end
  end

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic we);
    valid_i            = 1'b1;
    funct_i            = f;
    data_a_i           = a;
    data_b_i           = b;
    write_addr_i       = rd;
    int_write_enable_i = we;
    instr_i            = 32'h0200_0033 | (32'(rd) << 7) | (32'(f) << 12);
    pc_i               = pc_ctr;
    pc_ctr             = pc_ctr + 32'd4;
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic we, input logic [31:0] res,
                       input int lat);
    drive(f, a, b, rd, we);
    sbq.push_back('{cyc + lat, res, rd, we, instr_i, pc_i});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] e_hss;
  logic [31:0] e_huu;
  logic [31:0] e_hsu;

  initial begin
`ifdef MUL_HIGH_EN
    e_hss = 32'h0000_0000;
    e_huu = 32'hFFFF_FFFE;
    e_hsu = 32'hFFFF_FFFF;
`else
    e_hss = 32'h0000_0001;
    e_huu = 32'h0000_0001;
    e_hsu = 32'hFFFF_FFFE;
`endif
    rsn_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    valid_i = 1'b0; funct_i = 2'd0;
    data_a_i = '0; data_b_i = '0;
    write_addr_i = '0; int_write_enable_i = 1'b0;
    instr_i = '0; pc_i = '0;
    read_addr_a_i = '0; read_addr_b_i = '0;
    repeat (2) step();
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_pc", wb_pc_o, 32'd0);
    rsn_i = 1'b1;
    step();

    // plain MUL, single writeback exactly DEPTH cycles later
    issue(MUL_LO, 32'd7, 32'd6, 5'd3, 1'b1, 32'd42, DEPTH);
    step(); valid_i = 1'b0;
    repeat (7) step();

    // high-half variants back to back
    issue(MUL_HSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, e_hss, DEPTH);
    step();
    issue(MUL_HUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1, e_huu, DEPTH);
    step();
    issue(MUL_HSU, 32'hFFFF_FFFF, 32'd2, 5'd12, 1'b0, e_hsu, DEPTH);
    step(); valid_i = 1'b0;
    repeat (8) step();

    // hazard then bypass on rd=5
    read_addr_a_i = 5'd5; read_addr_b_i = 5'd5;
    issue(MUL_LO, 32'd3, 32'd5, 5'd5, 1'b1, 32'd15, DEPTH);
    step(); valid_i = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      chk("haz_a", 32'(hazard_a_o), 32'd1);
      chk("haz_b", 32'(hazard_b_o), 32'd1);
      chk("haz_nobyp", 32'(bypass_a_en_o), 32'd0);
      step();
    end
    chk("byp_haz_a", 32'(hazard_a_o), 32'd0);
    chk("byp_a", 32'(bypass_a_en_o), 32'd1);
    chk("byp_b", 32'(bypass_b_en_o), 32'd1);
    chk("byp_data", bypass_data_o, 32'd15);
    step();

    // x0 never hazards or bypasses
    read_addr_a_i = 5'd0; read_addr_b_i = 5'd0;
    issue(MUL_LO, 32'd2, 32'd2, 5'd0, 1'b1, 32'd4, DEPTH);
    step(); valid_i = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("x0_haz", 32'(hazard_a_o), 32'd0);
      chk("x0_byp", 32'(bypass_a_en_o), 32'd0);
      step();
    end

    // younger producer of same rd suppresses bypass
    read_addr_a_i = 5'd7;
    issue(MUL_LO, 32'd1, 32'd9, 5'd7, 1'b1, 32'd9, DEPTH);
    step(); valid_i = 1'b0;
    repeat (3) step();
    issue(MUL_LO, 32'd2, 32'd9, 5'd7, 1'b1, 32'd18, DEPTH);
    step(); valid_i = 1'b0;
    chk("prio_haz", 32'(hazard_a_o), 32'd1);
    chk("prio_nobyp", 32'(bypass_a_en_o), 32'd0);
    repeat (6) step();
    read_addr_a_i = 5'd0;

    // stall cycles 2-4 delay result to cycle 8, then hold in wb
    issue(MUL_LO, 32'd100, 32'd3, 5'd8, 1'b1, 32'd300, DEPTH + 3);
    step(); valid_i = 1'b0;
    step();
    stall_i = 1'b1;
    drive(MUL_LO, 32'd9, 32'd9, 5'd9, 1'b1);
    repeat (3) step();
    stall_i = 1'b0; valid_i = 1'b0;
    repeat (3) step();
    stall_i = 1'b1;
    step();
    chk("stall_hold_valid", 32'(wb_valid_o), 32'd1);
    step();
    stall_i = 1'b0;
    repeat (3) step();

    // flush with stall and valid: nothing survives
    drive(MUL_LO, 32'd4, 32'd4, 5'd13, 1'b1);
    step();
    drive(MUL_LO, 32'd5, 32'd4, 5'd14, 1'b1);
    step();
    drive(MUL_LO, 32'd6, 32'd4, 5'd15, 1'b1);
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_wb_we", 32'(wb_int_write_enable_o), 32'd0);
    repeat (7) step();
    issue(MUL_LO, 32'd5, 32'd5, 5'd1, 1'b1, 32'd25, DEPTH);
    step(); valid_i = 1'b0;
    repeat (7) step();

    // asynchronous reset mid-flight
    read_addr_a_i = 5'd16;
    drive(MUL_LO, 32'd9, 32'd9, 5'd16, 1'b1);
    step(); valid_i = 1'b0;
    repeat (2) step();
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    chk("pre_rst_haz", 32'(hazard_a_o), 32'd1);
    #1 rsn_i = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_haz", 32'(hazard_a_o), 32'd0);
    chk("arst_data", wb_data_o, 32'd0);
    chk("arst_instr", wb_instr_o, 32'd0);
    step();
    rsn_i = 1'b1;
    read_addr_a_i = 5'd0;
    repeat (8) step();

    chk("queue_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
